// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver, mid-bit sampling, break hold-off. Rev 1.0   |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_q;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_frame_err_q;
  logic             rx_busy_q;

  // Idle-high reset value keeps a reset release from looking like a start bit.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
    end
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      shift_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= 3'd0;
          if (!s2_q) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!s2_q) begin
              state_q <= DATA;
            end else begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {s2_q, shift_q[7:1]};
            // Index wraps 7 -> 0, leaving it cleared for the stop bit.
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (s2_q) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              rx_frame_err_q <= 1'b1;
              state_q        <= BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BREAK: begin
          cnt_q <= '0;
          idx_q <= 3'd0;
          if (s2_q) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          idx_q     <= 3'd0;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Testbench for uart_rx at 16 clocks per bit: directed corner cases, a vector
// table and randomized frames checked against a frame-level model.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int LAT  = 155;  // negedge index of strobe, relative to drive start
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk      (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         exp_err;
    logic [7:0] exp_rx_data;
  } vec_t;

  int   cyc = 0;
  int   overlap = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  evq[$];
  ev_t  modelq[$];
  bit   busy_hist [0:HMAX-1];
  vec_t vecs [7];
  logic [7:0] model_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HMAX) busy_hist[cyc] = rx_busy;
    if (rx_valid && rx_frame_err) overlap++;
    if (rx_valid) evq.push_back('{cyc, 1'b0, rx_data});
    if (rx_frame_err) evq.push_back('{cyc, 1'b1, rx_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first and stop; stops early after 'limit' cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int limit, output int c0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 10 * CPB && i < limit; i++) begin
      rx_in = bits[i / CPB];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input string name, input int exp_cyc, input bit exp_err,
                           input logic [7:0] exp_data);
    ev_t e;
    check({name, " present"}, 32'(evq.size() > 0), 32'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, " cycle"}, e.cyc, exp_cyc);
      check({name, " kind"}, 32'(e.err), 32'(exp_err));
      check({name, " data"}, 32'(e.data), 32'(exp_data));
    end
  endtask

  task automatic expect_none(input string name);
    check(name, evq.size(), 0);
    evq.delete();
  endtask

  initial begin
    int c0;
    int c1;
    int h;
    logic [7:0] b;
    bit st;
    int gap;
    ev_t e;
    ev_t m;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 1'b0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 8'h5A};

    // Reset values
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(50);
    expect_none("idle after reset no strobe");
    check("idle busy", 32'(rx_busy), 32'd0);

    // Nominal frame
    send_frame(8'hA5, 1'b1, 1000, c0);
    idle(20);
    expect_ev("nominal A5", c0 + LAT, 1'b0, 8'hA5);
    expect_none("nominal single strobe");
    check("nominal busy before E2", 32'(busy_hist[c0 + 2]), 32'd0);
    check("nominal busy at E2", 32'(busy_hist[c0 + 3]), 32'd1);
    check("nominal busy before strobe", 32'(busy_hist[c0 + LAT - 1]), 32'd1);
    check("nominal busy drops with strobe", 32'(busy_hist[c0 + LAT]), 32'd0);
    check("nominal rx_data", 32'(rx_data), 32'hA5);

    // Framing error and break
    send_frame(8'h3C, 1'b0, 1000, c0);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    h = cyc;
    idle(20);
    expect_ev("framing error", c0 + LAT, 1'b1, 8'hA5);
    expect_none("framing error single strobe");
    check("break rx_data held", 32'(rx_data), 32'hA5);
    check("break busy held", 32'(busy_hist[h + 2]), 32'd1);
    check("break busy released", 32'(busy_hist[h + 3]), 32'd0);
    send_frame(8'h81, 1'b1, 1000, c0);
    idle(20);
    expect_ev("after break 81", c0 + LAT, 1'b0, 8'h81);

    // Glitch rejection
    c0 = cyc;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(20);
    expect_none("glitch no strobe");
    check("glitch busy before E2", 32'(busy_hist[c0 + 2]), 32'd0);
    check("glitch busy at E2", 32'(busy_hist[c0 + 3]), 32'd1);
    check("glitch busy at E2+7", 32'(busy_hist[c0 + 10]), 32'd1);
    check("glitch idle at E2+8", 32'(busy_hist[c0 + 11]), 32'd0);
    send_frame(8'h5A, 1'b1, 1000, c0);
    idle(20);
    expect_ev("after glitch 5A", c0 + LAT, 1'b0, 8'h5A);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 1000, c0);
    send_frame(8'hFF, 1'b1, 1000, c1);
    idle(20);
    expect_ev("b2b first 00", c0 + LAT, 1'b0, 8'h00);
    expect_ev("b2b second FF", c0 + LAT + 160, 1'b0, 8'hFF);
    expect_none("b2b no extra strobe");

    // Vector table
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1000, c0);
      idle(20);
      expect_ev($sformatf("vec%0d", i), c0 + LAT, vecs[i].exp_err, vecs[i].exp_rx_data);
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx_data));
      expect_none($sformatf("vec%0d single strobe", i));
    end

    // Randomized frames against a frame-level model
    model_data = 8'h5A;
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom);
      st  = ($urandom_range(0, 4) != 0);
      gap = st ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10));
      send_frame(b, st, 1000, c0);
      if (st) model_data = b;
      modelq.push_back('{c0 + LAT, !st, model_data});
      idle(gap);
    end
    idle(20);
    check("random strobe count", evq.size(), modelq.size());
    while (evq.size() > 0 && modelq.size() > 0) begin
      e = evq.pop_front();
      m = modelq.pop_front();
      check("random cycle", e.cyc, m.cyc);
      check("random kind", 32'(e.err), 32'(m.err));
      check("random data", 32'(e.data), 32'(m.data));
    end
    evq.delete();

    // Reset mid-frame, during data bit 4
    send_frame(8'h77, 1'b1, CPB + 4 * CPB + 8, c0);
    #2 rst = 1'b1;
    #1;
    check("midreset rx_data", 32'(rx_data), 32'h00);
    check("midreset rx_busy", 32'(rx_busy), 32'd0);
    check("midreset rx_valid", 32'(rx_valid), 32'd0);
    check("midreset rx_frame_err", 32'(rx_frame_err), 32'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(200);
    expect_none("midreset no strobe");
    send_frame(8'h12, 1'b1, 1000, c0);
    idle(20);
    expect_ev("after reset 12", c0 + LAT, 1'b0, 8'h12);
    check("after reset rx_data", 32'(rx_data), 32'h12);

    check("valid and frame_err never together", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
